sdnet_to_mtpsa: RTL and testbench
=================================

# sdnet_to_mtpsa

Egress-side adapter between the SDNet pipeline output and the SUME AXI4-Stream datapath of the MTPSA switch; the mirror of the ingress-side mtpsa_to_sdnet adapter. It captures each per-packet metadata tuple emitted by SDNet into a small tuple FIFO. It forwards the SDNet packet stream to SUME with that tuple placed on tuser of the packet's first beat. It stalls SDNet whenever a first beat has no tuple available yet.

## Interface
Parameters:
- TDATA_WIDTH, 256, packet data width
- TUPLE_WIDTH, 128, metadata tuple width; equals SUME tuser width
- TUPLE_FIFO_DEPTH, 4, tuple FIFO entries; power of two, >= 2

Ports:
- Clocking and reset: one clock, axis_aclk; reset axis_resetn is asynchronous and active-low.
- axis_aclk  in  1  clock
- axis_resetn  in  1  asynchronous active-low reset
- SDNet_out_TVALID  in  1  SDNet packet beat valid
- SDNet_out_TDATA  in  TDATA_WIDTH  packet data
- SDNet_out_TKEEP  in  TDATA_WIDTH/8  byte enables
- SDNet_out_TLAST  in  1  last beat of packet
- SDNet_out_TREADY  out  1  backpressure to SDNet
- SDNet_tuple_VALID  in  1  one-cycle strobe, tuple for next packet
- SDNet_tuple_DATA  in  TUPLE_WIDTH  tuple contents (sume_metadata)
- m_axis_tdata  out  TDATA_WIDTH  to SUME
- m_axis_tkeep  out  TDATA_WIDTH/8  to SUME
- m_axis_tuser  out  TUPLE_WIDTH  tuple on first beat, else 0
- m_axis_tvalid  out  1  to SUME
- m_axis_tlast  out  1  to SUME
- m_axis_tready  in  1  from SUME
- tuple_overflow  out  1  sticky: a tuple was dropped because the FIFO was full
- pkt_count  out  32  packets forwarded; wraps at 2^32

## Operation
- Tuple FIFO:
  - Push SDNet_tuple_DATA when SDNet_tuple_VALID=1 and the FIFO is not full.
  - Push while full: drop the tuple, set tuple_overflow; it stays set until reset.
  - Push and pop in the same cycle while full: allowed; the push is accepted and occupancy is unchanged.
  - No bypass: a pushed tuple becomes visible at the head the cycle after the push.
  - Pointers are log2(TUPLE_FIFO_DEPTH) bits wide and wrap naturally; occupancy is tracked with a count of width log2(DEPTH)+1.
- FSM, states FIRST and BODY; reset state FIRST.
  - FIRST, FIFO empty:
    - m_axis_tvalid=0
    - SDNet_out_TREADY=0
  - FIRST, FIFO not empty:
    - m_axis_tvalid=SDNet_out_TVALID
    - SDNet_out_TREADY=m_axis_tready
    - m_axis_tuser=FIFO head
  - FIRST, on handshake (m_axis_tvalid & m_axis_tready):
    - pop the FIFO
    - increment pkt_count if TLAST=1
    - next state is FIRST if TLAST=1, else BODY
  - BODY:
    - m_axis_tvalid=SDNet_out_TVALID
    - SDNet_out_TREADY=m_axis_tready
    - m_axis_tuser=0
  - BODY, on handshake with TLAST=1: go to FIRST and increment pkt_count.
- tdata, tkeep, tlast are combinational pass-through from SDNet_out.
- m_axis_tlast = SDNet_out_TVALID & SDNet_out_TLAST; it is never high without valid.
- tuple_VALID arriving mid-packet is queued for a later packet; it never alters the packet in flight.

## Timing
- Zero-cycle latency on data and handshake; the only registered state is the FSM, the FIFO, tuple_overflow and pkt_count.
- Tuple-to-availability latency: 1 cycle. A tuple strobed in cycle N allows a first-beat handshake in cycle N+1 at the earliest.
- Values during reset and immediately after:
  - state FIRST, FIFO empty
  - m_axis_tvalid=0, SDNet_out_TREADY=0, m_axis_tuser=0
  - tuple_overflow=0, pkt_count=0
- Reset asserted mid-packet:
  - everything clears immediately, asynchronously
  - the remaining beats of that packet are treated as a new first beat once a tuple exists; upstream reset is expected to accompany this.
- AXI rules: the data, tuser and tlast outputs are stable while m_axis_tvalid=1 and m_axis_tready=0, provided SDNet holds its outputs stable, as AXI requires.

## Test plan
- Single 1-beat packet: tuple 0xA5 strobed at cycle 0, beat presented at cycle 0, tready=1 throughout. Required: tvalid=0 at cycle 0; handshake at cycle 1 with tuser=0xA5 and tlast=1; FIFO empty afterwards; pkt_count=1.
- 3-beat packet, tuple 0x11: beat 1 carries tuser=0x11, beats 2-3 carry tuser=0. Random m_axis_tready stalls must not change or lose any beat; data is checked against a scoreboard.
- Data before tuple: SDNet_out_TVALID=1 for 5 cycles with no tuple. Required: SDNet_out_TREADY=0 and m_axis_tvalid=0 for all 5 cycles; forwarding starts 1 cycle after the tuple strobe.
- Overflow: strobe 5 tuples (1..5) back to back with DEPTH=4 and no packets. Required: tuple_overflow=1 from the cycle after the 5th strobe; the next 4 packets carry tusers 1,2,3,4.
- Full FIFO with simultaneous pop and push: tuple 6 is accepted, tuple_overflow is unchanged, and the order of the following packets is preserved.
- Async reset asserted mid-BODY:
  - Required immediately: state FIRST, m_axis_tvalid=0, pkt_count=0.
  - After release: a normal tuple+packet sequence forwards correctly.

Source files
------------

// File: rtl/sdnet_to_mtpsa_if.sv
// Stream and tuple signals between SDNet's egress, the adapter and the SUME datapath.
// The slave view is the adapter; the master view is the surrounding environment.
interface sdnet_to_mtpsa_if #(
    parameter int TDATA_WIDTH = 256,
    parameter int TUPLE_WIDTH = 128
);
    logic                       SDNet_out_TVALID;
    logic [TDATA_WIDTH-1:0]     SDNet_out_TDATA;
    logic [TDATA_WIDTH/8-1:0]   SDNet_out_TKEEP;
    logic                       SDNet_out_TLAST;
    logic                       SDNet_out_TREADY;
    logic                       SDNet_tuple_VALID;
    logic [TUPLE_WIDTH-1:0]     SDNet_tuple_DATA;
    logic [TDATA_WIDTH-1:0]     m_axis_tdata;
    logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep;
    logic [TUPLE_WIDTH-1:0]     m_axis_tuser;
    logic                       m_axis_tvalid;
    logic                       m_axis_tlast;
    logic                       m_axis_tready;

    modport slave (
        input  SDNet_out_TVALID, SDNet_out_TDATA, SDNet_out_TKEEP, SDNet_out_TLAST,
        input  SDNet_tuple_VALID, SDNet_tuple_DATA, m_axis_tready,
        output SDNet_out_TREADY, m_axis_tdata, m_axis_tkeep, m_axis_tuser,
        output m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output SDNet_out_TVALID, SDNet_out_TDATA, SDNet_out_TKEEP, SDNet_out_TLAST,
        output SDNet_tuple_VALID, SDNet_tuple_DATA, m_axis_tready,
        input  SDNet_out_TREADY, m_axis_tdata, m_axis_tkeep, m_axis_tuser,
        input  m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/sdnet_to_mtpsa.sv
// Egress adapter: queues SDNet metadata tuples and attaches each one to the tuser of
// the first beat of the next packet forwarded to SUME, stalling SDNet until one exists.
module sdnet_to_mtpsa #(
    parameter int TDATA_WIDTH      = 256,
    parameter int TUPLE_WIDTH      = 128,
    parameter int TUPLE_FIFO_DEPTH = 4
) (
    input  logic                axis_aclk,
    input  logic                axis_resetn,
    sdnet_to_mtpsa_if.slave     bus,
    output logic                tuple_overflow,
    output logic [31:0]         pkt_count
);
    localparam int AW = $clog2(TUPLE_FIFO_DEPTH);

    typedef enum logic {FIRST, BODY} state_t;
    state_t state, state_nx;

    logic [TUPLE_WIDTH-1:0] fifo_mem [TUPLE_FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   empty, full, push, pop, drop, pkt_done, beat_hs;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(TUPLE_FIFO_DEPTH));
    assign beat_hs = bus.SDNet_out_TVALID && bus.m_axis_tready;

    assign bus.m_axis_tdata = bus.SDNet_out_TDATA;
    assign bus.m_axis_tkeep = bus.SDNet_out_TKEEP;
    assign bus.m_axis_tlast = bus.SDNet_out_TVALID && bus.SDNet_out_TLAST;

    always_comb begin
        state_nx             = state;
        bus.m_axis_tvalid    = 1'b0;
        bus.SDNet_out_TREADY = 1'b0;
        bus.m_axis_tuser     = '0;
        pop                  = 1'b0;
        pkt_done             = 1'b0;
        case (state)
            FIRST: begin
                // A first beat may only leave once its tuple is at the FIFO head.
                if (!empty) begin
                    bus.m_axis_tvalid    = bus.SDNet_out_TVALID;
                    bus.SDNet_out_TREADY = bus.m_axis_tready;
                    bus.m_axis_tuser     = fifo_mem[rd_ptr];
                    if (beat_hs) begin
                        pop = 1'b1;
                        if (bus.SDNet_out_TLAST) pkt_done = 1'b1;
                        else                     state_nx = BODY;
                    end
                end
            end
            BODY: begin
                bus.m_axis_tvalid    = bus.SDNet_out_TVALID;
                bus.SDNet_out_TREADY = bus.m_axis_tready;
                if (beat_hs && bus.SDNet_out_TLAST) begin
                    pkt_done = 1'b1;
                    state_nx = FIRST;
                end
            end
        endcase
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
    assign push = bus.SDNet_tuple_VALID && (!full || pop);
    assign drop = bus.SDNet_tuple_VALID && full && !pop;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state          <= FIRST;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            tuple_overflow <= 1'b0;
            pkt_count      <= '0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (drop)     tuple_overflow <= 1'b1;
            if (pkt_done) pkt_count <= pkt_count + 32'd1;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (push) fifo_mem[wr_ptr] <= bus.SDNet_tuple_DATA;
    end
endmodule

// File: tb/tb_sdnet_to_mtpsa.sv
// Directed-sequence bench with randomized beats, stalls and tuples, checked against a
// queue-based model of tuple availability, packet boundaries and counters.
module tb_sdnet_to_mtpsa;
    localparam int DW = 256;
    localparam int TW = 128;
    localparam int KW = DW / 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdnet_to_mtpsa_if #(.TDATA_WIDTH(DW), .TUPLE_WIDTH(TW)) bus ();
    logic        ovf;
    logic [31:0] pcnt;

    sdnet_to_mtpsa #(.TDATA_WIDTH(DW), .TUPLE_WIDTH(TW), .TUPLE_FIFO_DEPTH(DEPTH)) dut (
        .axis_aclk      (clk),
        .axis_resetn    (rst_n),
        .bus            (bus),
        .tuple_overflow (ovf),
        .pkt_count      (pcnt)
    );

    int checks = 0;
    int errors = 0;
    int stall_pct = 0;
    bit last_hs = 0;

    // Reference model: tuples waiting, whether a packet is mid-flight, counters.
    logic [TW-1:0] tq[$];
    bit            in_pkt = 0;
    logic [31:0]   m_cnt = 0;
    bit            m_ovf = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tq.delete();
        in_pkt = 0;
        m_cnt  = 0;
        m_ovf  = 0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit            avail, e_v, e_r, hs;
        logic [TW-1:0] e_u;
        #3;
        avail = in_pkt || (tq.size() > 0);
        e_v   = avail && bus.SDNet_out_TVALID;
        e_r   = avail && bus.m_axis_tready;
        e_u   = (!in_pkt && tq.size() > 0) ? tq[0] : '0;
        hs    = e_v && bus.m_axis_tready;
        chk("tvalid", bus.m_axis_tvalid, e_v);
        chk("sdnet_tready", bus.SDNet_out_TREADY, e_r);
        chk("tuser", bus.m_axis_tuser, e_u);
        chk("tlast", bus.m_axis_tlast, bus.SDNet_out_TVALID & bus.SDNet_out_TLAST);
        chk("pkt_count", pcnt, m_cnt);
        chk("overflow", ovf, m_ovf);
        if (hs) begin
            chk("tdata", bus.m_axis_tdata, bus.SDNet_out_TDATA);
            chk("tkeep", bus.m_axis_tkeep, bus.SDNet_out_TKEEP);
        end
        @(posedge clk);
        if (hs) begin
            if (!in_pkt) void'(tq.pop_front());
            if (bus.SDNet_out_TLAST) begin
                m_cnt++;
                in_pkt = 0;
            end else begin
                in_pkt = 1;
            end
        end
        if (bus.SDNet_tuple_VALID) begin
            if (tq.size() < DEPTH) tq.push_back(bus.SDNet_tuple_DATA);
            else                   m_ovf = 1;
        end
        last_hs = hs;
        #1;
        bus.SDNet_tuple_VALID = 1'b0;
    endtask

    // Send one packet; strobe tuple tval at relative cycle tcyc (negative: none).
    task automatic send_pkt(input int len, input int tcyc, input logic [TW-1:0] tval,
                            output int first_cyc);
        int c;
        logic [DW-1:0] d;
        c = 0;
        first_cyc = -1;
        for (int b = 0; b < len; b++) begin
            for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
            bus.SDNet_out_TVALID = 1'b1;
            bus.SDNet_out_TDATA  = d;
            bus.SDNet_out_TKEEP  = $urandom;
            bus.SDNet_out_TLAST  = (b == len - 1);
            do begin
                if (c == tcyc) begin
                    bus.SDNet_tuple_VALID = 1'b1;
                    bus.SDNet_tuple_DATA  = tval;
                end
                bus.m_axis_tready = ($urandom_range(99) >= stall_pct);
                tick();
                c++;
                if (c > 300) begin
                    checks++;
                    assert (c <= 300) else begin
                        errors++;
                        $error("FAIL timeout observed=%0d cycles expected<=300", c);
                    end
                    bus.SDNet_out_TVALID = 1'b0;
                    return;
                end
            end while (!last_hs);
            if (b == 0) first_cyc = c - 1;
        end
        bus.SDNet_out_TVALID = 1'b0;
        bus.SDNet_out_TLAST  = 1'b0;
    endtask

    task automatic strobe(input logic [TW-1:0] v);
        bus.SDNet_tuple_VALID = 1'b1;
        bus.SDNet_tuple_DATA  = v;
        tick();
    endtask

    initial begin
        int fc;
        bus.SDNet_out_TVALID  = 1'b1;
        bus.SDNet_out_TDATA   = '0;
        bus.SDNet_out_TKEEP   = '1;
        bus.SDNet_out_TLAST   = 1'b0;
        bus.SDNet_tuple_VALID = 1'b0;
        bus.SDNet_tuple_DATA  = '0;
        bus.m_axis_tready     = 1'b1;
        model_reset();

        // Values while in reset, with upstream valid and downstream ready asserted.
        #2;
        chk("rst_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("rst_sdnet_tready", bus.SDNet_out_TREADY, 1'b0);
        chk("rst_tuser", bus.m_axis_tuser, '0);
        chk("rst_overflow", ovf, 1'b0);
        chk("rst_pkt_count", pcnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.SDNet_out_TVALID = 1'b0;
        @(posedge clk);
        #1;

        // Single 1-beat packet, tuple and beat in the same cycle.
        stall_pct = 0;
        send_pkt(1, 0, 128'hA5, fc);
        chk("one_beat_first_cycle", fc, 1);
        chk("one_beat_pkt_count", pcnt, 32'd1);
        bus.SDNet_out_TVALID = 1'b1;
        bus.SDNet_out_TLAST  = 1'b1;
        tick();
        bus.SDNet_out_TVALID = 1'b0;

        // 3-beat packet under random downstream stalls.
        stall_pct = 40;
        send_pkt(3, 0, 128'h11, fc);
        chk("three_beat_pkt_count", pcnt, 32'd2);

        // Data waits five cycles for its tuple.
        stall_pct = 0;
        send_pkt(2, 5, 128'h77, fc);
        chk("late_tuple_first_cycle", fc, 6);

        // Full FIFO: pop and push in the same cycle.
        bus.SDNet_out_TVALID = 1'b0;
        for (int i = 10; i < 14; i++) strobe(TW'(i));
        send_pkt(1, 0, 128'h6, fc);
        chk("full_pushpop_first_cycle", fc, 0);
        for (int i = 0; i < 4; i++) send_pkt($urandom_range(1, 3), -1, '0, fc);
        chk("full_pushpop_no_overflow", ovf, 1'b0);

        // Overflow: five tuples into four slots.
        for (int i = 1; i <= 5; i++) strobe(TW'(i));
        chk("overflow_set", ovf, 1'b1);
        stall_pct = 30;
        for (int i = 0; i < 4; i++) send_pkt($urandom_range(1, 4), -1, '0, fc);

        // Random packets with tuples arriving before, with or during the packet.
        for (int p = 0; p < 25; p++) begin
            logic [TW-1:0] t;
            for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = $urandom;
            send_pkt($urandom_range(1, 4), $urandom_range(0, 4), t, fc);
        end

        // Asynchronous reset in the middle of a packet.
        stall_pct = 0;
        strobe(128'h3C);
        bus.SDNet_out_TVALID = 1'b1;
        bus.SDNet_out_TLAST  = 1'b0;
        bus.m_axis_tready    = 1'b1;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("midrst_sdnet_tready", bus.SDNet_out_TREADY, 1'b0);
        chk("midrst_pkt_count", pcnt, 32'd0);
        chk("midrst_overflow", ovf, 1'b0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.SDNet_out_TVALID = 1'b0;
        send_pkt(3, 0, 128'h5A, fc);
        chk("post_reset_pkt_count", pcnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
